// File: rtl/tdc_sync_decoder_if.sv
// rtl/tdc_sync_decoder_if.sv - result handshake bundle of the counting TDC decoder
interface tdc_sync_decoder_if #(
  parameter int W = 8
);
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         overflow;

  modport master (
    output out,
    output out_valid,
    output overflow,
    input  out_ready
  );

  modport slave (
    input  out,
    input  out_valid,
    input  overflow,
    output out_ready
  );
endinterface

// File: rtl/tdc_sync_decoder.sv
// rtl/tdc_sync_decoder.sv - counts clk cycles from start strobe to first synchronized rising edge of in
module tdc_sync_decoder #(
  parameter int W       = 8,
  parameter int OFFSET  = 2,
  parameter int MAX_CNT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in,
  output logic                 busy,
  output logic                 missed,
  tdc_sync_decoder_if.master   res
);

  localparam logic [W-1:0] CNT_MAX = W'(MAX_CNT);
  localparam logic [W-1:0] CNT_OFF = W'(OFFSET);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] out_q, out_d;
  logic         ovf_q, ovf_d;
  logic         missed_q, missed_d;
  logic         s1_q, s1_d;
  logic         s2_q, s2_d;
  logic         s3_q, s3_d;
  logic         edge_det;

  // s3 only delays s2 so the edge detector sees a fresh low->high transition
  assign s1_d     = in;
  assign s2_d     = s1_q;
  assign s3_d     = s2_q;
  assign edge_det = s2_q & ~s3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      missed_q <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      missed_q <= missed_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COUNT;
      COUNT:   if (edge_det || (cnt_q == CNT_MAX)) state_d = DONE;
      DONE:    if (res.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    missed_d = missed_q | (start & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (start) cnt_d = '0;
      end
      COUNT: begin
        // an edge before OFFSET cycles means in was already rising at start
        if (edge_det) begin
          out_d = (cnt_q >= CNT_OFF) ? (cnt_q - CNT_OFF) : '0;
          ovf_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          out_d = CNT_MAX;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      DONE: begin
        if (res.out_ready) ovf_d = 1'b0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    missed        = missed_q;
    res.out_valid = (state_q == DONE);
    res.out       = out_q;
    res.overflow  = ovf_q;
  end

endmodule

// File: tb/tb_tdc_sync_decoder.sv
// tb/tb_tdc_sync_decoder.sv - scoreboard bench for tdc_sync_decoder with directed vectors
module tb_tdc_sync_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_sig = 1'b0;
  logic busy;
  logic missed;

  tdc_sync_decoder_if #(.W(8)) res_if ();

  tdc_sync_decoder #(.W(8), .OFFSET(2), .MAX_CNT(255)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in     (in_sig),
    .busy   (busy),
    .missed (missed),
    .res    (res_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst && res_if.out_valid && res_if.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got out=%0d ovf=%0d expected no output",
                 res_if.out, res_if.overflow);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_code", 32'(res_if.out), 32'(mon_e.code));
        chk("sb_ovf", 32'(res_if.overflow), 32'(mon_e.ovf));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!res_if.out_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!res_if.out_valid) begin
      errors++;
      $display("FAIL %s_timeout: got out_valid=0 expected out_valid=1 within 400 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    res_if.out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(res_if.out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_missed", 32'(missed), 0);
    chk("rst_out", 32'(res_if.out), 0);
    chk("rst_overflow", 32'(res_if.overflow), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // edge sampled at cnt=40
    exp_q.push_back('{code: 8'd40, ovf: 1'b0});
    pulse_start();
    chk("t1_busy", 32'(busy), 1);
    repeat (40) tick();
    in_sig = 1'b1;
    wait_valid("t1");
    @(negedge clk);
    chk("t1_valid_one_cycle", 32'(res_if.out_valid), 0);
    chk("t1_idle", 32'(busy), 0);

    // no edge: timeout
    tick();
    in_sig = 1'b0;
    repeat (3) tick();
    exp_q.push_back('{code: 8'd255, ovf: 1'b1});
    pulse_start();
    wait_valid("t2");
    @(negedge clk);
    chk("t2_idle", 32'(busy), 0);
    chk("t2_ovf_clear", 32'(res_if.overflow), 0);

    // steady-high in before start: stale level ignored
    tick();
    in_sig = 1'b1;
    repeat (4) tick();
    exp_q.push_back('{code: 8'd255, ovf: 1'b1});
    pulse_start();
    wait_valid("t3a");
    @(negedge clk);
    chk("t3a_idle", 32'(busy), 0);

    // edge right at start saturates to 0
    tick();
    in_sig = 1'b0;
    repeat (3) tick();
    exp_q.push_back('{code: 8'd0, ovf: 1'b0});
    in_sig = 1'b1;
    pulse_start();
    wait_valid("t3b");
    @(negedge clk);
    chk("t3b_idle", 32'(busy), 0);

    // backpressure for 10 cycles
    tick();
    in_sig = 1'b0;
    repeat (3) tick();
    res_if.out_ready = 1'b0;
    exp_q.push_back('{code: 8'd7, ovf: 1'b0});
    pulse_start();
    repeat (7) tick();
    in_sig = 1'b1;
    wait_valid("t4");
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 32'(res_if.out_valid), 1);
      chk("t4_hold_out", 32'(res_if.out), 7);
      chk("t4_hold_ovf", 32'(res_if.overflow), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 res_if.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_idle_after_hs", 32'(busy), 0);
    chk("t4_valid_after_hs", 32'(res_if.out_valid), 0);
    chk("t4_no_missed", 32'(missed), 0);

    // start in COUNT and in DONE is dropped and sets missed
    tick();
    in_sig = 1'b0;
    repeat (3) tick();
    res_if.out_ready = 1'b0;
    exp_q.push_back('{code: 8'd12, ovf: 1'b0});
    pulse_start();
    repeat (3) tick();
    pulse_start();
    chk("t5_missed_count", 32'(missed), 1);
    repeat (8) tick();
    in_sig = 1'b1;
    wait_valid("t5");
    @(posedge clk);
    #1;
    pulse_start();
    chk("t5_done_valid", 32'(res_if.out_valid), 1);
    chk("t5_done_out", 32'(res_if.out), 12);
    chk("t5_missed_done", 32'(missed), 1);
    res_if.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_idle", 32'(busy), 0);
    chk("t5_missed_sticky", 32'(missed), 1);

    // glitch edge in IDLE
    tick();
    in_sig = 1'b0;
    repeat (3) tick();
    in_sig = 1'b1;
    tick();
    in_sig = 1'b0;
    repeat (6) tick();
    chk("t5_glitch_valid", 32'(res_if.out_valid), 0);
    chk("t5_glitch_busy", 32'(busy), 0);

    // async reset mid-COUNT at cnt=17
    pulse_start();
    repeat (17) tick();
    chk("t6_busy_before", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_out_valid", 32'(res_if.out_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_missed", 32'(missed), 0);
    chk("t6_out", 32'(res_if.out), 0);
    chk("t6_overflow", 32'(res_if.overflow), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) tick();
    exp_q.push_back('{code: 8'd25, ovf: 1'b0});
    pulse_start();
    repeat (25) tick();
    in_sig = 1'b1;
    wait_valid("t6");
    @(negedge clk);
    chk("t6_idle", 32'(busy), 0);
    chk("t6_missed_after", 32'(missed), 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
